data_path: RTL and testbench
============================

Name: data_path

Overview:
- 32-bit single-bus CPU datapath: general registers, PC, IR, MAR, MDR, Y, 64-bit Z, HI/LO, and an ALU.
- Driven cycle by cycle by external control strobes (the control unit, or a bench standing in for it).
- One shared bus. Each register loads from it on its *in strobe and drives it on its *out strobe.
- The ALU computes from Y (operand A) and the bus (operand B) into Z.

Parameters:
- WIDTH, 32, datapath word width; Z is 2*WIDTH.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  reset; one clock, synchronous, active-high; all registers load 0.
- PCout, ZHighout, Zlowout, MDRout  in  1 each  bus drive selects for PC, Z[63:32], Z[31:0], MDR.
- R2out..R7out  in  1 each  bus drive selects for R2..R7.
- MARin, PCin, MDRin, IRin, Yin  in  1 each  load enables.
- IncPC  in  1  PC increment.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- ROR  in  5  ALU operation select (opcode table below).
- R1in..R15in  in  1 each  load enables for R1..R15.
- HIin, LOin  in  1 each  HI/LO load from bus.
- ZHighIn, ZLowIn  in  1 each  Z[63:32] / Z[31:0] load from ALU result.
- Cin  in  1  carry-in for ADD.
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value (observation).
- MARout  out  32  MAR contents (memory address).

Behaviour:
- Bus is combinational. Drive priority: MDRout > PCout > Zlowout > ZHighout > R2out > … > R7out. Bus = 0 when no out strobe is asserted.
- Register loads on the rising edge:
  - Clear wins over everything; all registers go to 0, including R1–R15, HI, LO, PC, IR, MAR, MDR, Y, Z.
  - Each *in strobe loads its register from the bus.
  - MDRin loads Read ? Mdatain : bus.
- PC priority: Clear, then IncPC (PC+1), then PCin (bus).
- Z loads: ZLowIn loads result[31:0]; ZHighIn loads result[63:32]; either or both may be asserted in a cycle.
- Latency: register-to-register move takes 1 cycle. ALU result is combinational from Y and bus, captured into Z on the same edge.
- Opcode table; A = Y, B = bus, sh = A[4:0]:
  - 00000 ADD: A+B+Cin.
  - 00001 SUB: A−B.
  - 00010 AND.
  - 00011 OR.
  - 00100 SHR: B>>sh, logical.
  - 00101 SHRA: B>>>sh, arithmetic.
  - 00110 SHL: B<<sh.
  - 00111 ROR: B rotated right by sh.
  - 01000 ROL: B rotated left by sh.
  - 01001 MUL: signed A*B, full 64 bits.
  - 01010 DIV: A/B signed; low = quotient, high = remainder.
  - 01011 NEG: −B.
  - 01100 NOT: ~B.
  - Other codes: result 0.
- High half: for all operations except MUL and DIV, result[63:32] = 0. ADD/SUB carry-out is discarded.
- Divide by zero: quotient = 0, remainder = A.
- Rotate/shift amount 0 returns B unchanged.
- Simultaneous load and drive of the same register: the bus carries the old value; the register captures the bus value.
- Clear asserted mid-sequence: all state is 0 after the edge; the strobes in that cycle are ignored.

Decomposition:
- Shared package dp_pkg holds:
  - WIDTH;
  - the 5-bit ALU opcode constants (ADD…NOT as above);
  - an alu_op_t typedef.
- One sub-module, dp_alu: combinational, inputs A, B, op, Cin; output 64-bit result.
- Registers and bus mux stay in data_path.

Test Plan:
- ROR load/rotate sequence:
  - Mdatain = 0x12 with Read+MDRin, then MDRout+R4in.
  - Load R3 = 0x7F and R7 = 0x01 the same way.
  - R7out+Yin; then R3out, ROR = 00111, ZLowIn; then Zlowout+R4in.
  - → BusMuxOut = 0x8000003F while R4 is loaded.
- ADD with carry: Y = 0x12, bus = 0x7F, op 00000, Cin = 1 → Z low = 0x00000092, Z high = 0.
- MUL: Y = 0x7F, bus = 0x12, op 01001, ZHighIn+ZLowIn → Z low = 0x000008EE, Z high = 0. Repeat with Y = 0xFFFFFFFF, bus = 2 → Z = 0xFFFFFFFF_FFFFFFFE.
- DIV by zero: Y = 7, bus = 0, op 01010 → Z low = 0, Z high = 7.
- Instruction fetch:
  - MDRout+PCin with MDR = 7 → PC = 7.
  - PCout+MARin+IncPC → MARout = 7, PC = 8.
  - Read+MDRin with Mdatain = 0x3A1B8000, then MDRout+IRin → IR = 0x3A1B8000.
- Clear after registers are loaded: Clear high for one edge → PCout, Zlowout, R4out-equivalent reads and MARout all show 0; no out strobe → BusMuxOut = 0.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the single-bus CPU datapath: word width and ALU opcodes.
package dp_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = $clog2(WIDTH);

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00001,
        OP_AND  = 5'b00010,
        OP_OR   = 5'b00011,
        OP_SHR  = 5'b00100,
        OP_SHRA = 5'b00101,
        OP_SHL  = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_MUL  = 5'b01001,
        OP_DIV  = 5'b01010,
        OP_NEG  = 5'b01011,
        OP_NOT  = 5'b01100
    } alu_op_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: A comes from Y, B from the bus; produces a double-width result for Z.
module dp_alu
    import dp_pkg::*;
(
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  alu_op_t            op,
    input  logic               cin,
    output logic [2*WIDTH-1:0] result
);

    logic [SHW-1:0]           sh;
    logic [2*WIDTH-1:0]       dbl;
    logic [2*WIDTH-1:0]       rot;
    logic signed [2*WIDTH-1:0] prod;

    assign sh = a[SHW-1:0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        result = '0;
        dbl    = {b, b};
        rot    = '0;
        prod   = '0;
        case (op)
            OP_ADD:  result[WIDTH-1:0] = a + b + {{(WIDTH-1){1'b0}}, cin};
            OP_SUB:  result[WIDTH-1:0] = a - b;
            OP_AND:  result[WIDTH-1:0] = a & b;
            OP_OR:   result[WIDTH-1:0] = a | b;
            OP_SHR:  result[WIDTH-1:0] = b >> sh;
            OP_SHRA: result[WIDTH-1:0] = $signed(b) >>> sh;
            OP_SHL:  result[WIDTH-1:0] = b << sh;
            // Rotates shift a doubled copy of B and pick the half that wrapped around.
            OP_ROR: begin
                rot               = dbl >> sh;
                result[WIDTH-1:0] = rot[WIDTH-1:0];
            end
            OP_ROL: begin
                rot               = dbl << sh;
                result[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
            end
            OP_MUL: begin
                prod   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
                result = prod;
            end
            OP_DIV: begin
                if (b == '0) begin
                    result[2*WIDTH-1:WIDTH] = a;
                end else begin
                    result[WIDTH-1:0]       = $signed(a) / $signed(b);
                    result[2*WIDTH-1:WIDTH] = $signed(a) % $signed(b);
                end
            end
            OP_NEG:  result[WIDTH-1:0] = -b;
            OP_NOT:  result[WIDTH-1:0] = ~b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: register set, PC/IR/MAR/MDR, Y, Z, HI/LO around one shared bus and an ALU.
module data_path
    import dp_pkg::*;
(
    input  logic             Clock,
    input  logic             Clear,
    input  logic             PCout,
    input  logic             ZHighout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             R6out,
    input  logic             R7out,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic [4:0]       ROR,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             R6in,
    input  logic             R7in,
    input  logic             R8in,
    input  logic             R9in,
    input  logic             R10in,
    input  logic             R11in,
    input  logic             R12in,
    input  logic             R13in,
    input  logic             R14in,
    input  logic             R15in,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             ZHighIn,
    input  logic             ZLowIn,
    input  logic             Cin,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] MARout
);

    logic [WIDTH-1:0]   pc, ir, mar, mdr, y, hi, lo;
    logic [2*WIDTH-1:0] z;
    logic [WIDTH-1:0]   r [1:15];
    logic [15:1]        r_in;
    logic [2*WIDTH-1:0] alu_result;

    assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in};

    always_comb begin
        if (MDRout)        BusMuxOut = mdr;
        else if (PCout)    BusMuxOut = pc;
        else if (Zlowout)  BusMuxOut = z[WIDTH-1:0];
        else if (ZHighout) BusMuxOut = z[2*WIDTH-1:WIDTH];
        else if (R2out)    BusMuxOut = r[2];
        else if (R3out)    BusMuxOut = r[3];
        else if (R4out)    BusMuxOut = r[4];
        else if (R5out)    BusMuxOut = r[5];
        else if (R6out)    BusMuxOut = r[6];
        else if (R7out)    BusMuxOut = r[7];
        else               BusMuxOut = '0;
    end

    dp_alu u_alu (
        .a      (y),
        .b      (BusMuxOut),
        .op     (alu_op_t'(ROR)),
        .cin    (Cin),
        .result (alu_result)
    );

    // NOTE: state uses non-blocking assignments so every register samples the pre-edge bus together.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            hi  <= '0;
            lo  <= '0;
            z   <= '0;
            // NOTE: the register file is architectural state, so Clear zeroes every entry.
            for (int i = 1; i <= 15; i++) r[i] <= '0;
        end else begin
            if (IncPC)     pc <= pc + WIDTH'(1);
            else if (PCin) pc <= BusMuxOut;
            if (IRin)  ir  <= BusMuxOut;
            if (MARin) mar <= BusMuxOut;
            if (MDRin) mdr <= Read ? Mdatain : BusMuxOut;
            if (Yin)   y   <= BusMuxOut;
            if (HIin)  hi  <= BusMuxOut;
            if (LOin)  lo  <= BusMuxOut;
            if (ZLowIn)  z[WIDTH-1:0]       <= alu_result[WIDTH-1:0];
            if (ZHighIn) z[2*WIDTH-1:WIDTH] <= alu_result[2*WIDTH-1:WIDTH];
            for (int i = 1; i <= 15; i++) begin
                if (r_in[i]) r[i] <= BusMuxOut;
            end
        end
    end

    assign MARout = mar;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: bus transfers, ALU ops into Z, instruction fetch and Clear.
module tb_data_path;
    import dp_pkg::*;

    logic Clock, Clear;
    logic PCout, ZHighout, Zlowout, MDRout;
    logic R2out, R3out, R4out, R5out, R6out, R7out;
    logic MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic [4:0] ROR;
    logic R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in;
    logic R9in, R10in, R11in, R12in, R13in, R14in, R15in;
    logic HIin, LOin, ZHighIn, ZLowIn, Cin;
    logic [31:0] Mdatain, BusMuxOut, MARout;

    int tests = 0;
    int fails = 0;

    data_path dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .ROR(ROR),
        .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in), .R6in(R6in),
        .R7in(R7in), .R8in(R8in), .R9in(R9in), .R10in(R10in), .R11in(R11in), .R12in(R12in),
        .R13in(R13in), .R14in(R14in), .R15in(R15in),
        .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin),
        .Mdatain(Mdatain), .BusMuxOut(BusMuxOut), .MARout(MARout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic idle();
        Clear = 0; PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0;
        R2out = 0; R3out = 0; R4out = 0; R5out = 0; R6out = 0; R7out = 0;
        MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; IncPC = 0; Read = 0;
        ROR = 5'b0; Cin = 0;
        R1in = 0; R2in = 0; R3in = 0; R4in = 0; R5in = 0; R6in = 0; R7in = 0; R8in = 0;
        R9in = 0; R10in = 0; R11in = 0; R12in = 0; R13in = 0; R14in = 0; R15in = 0;
        HIin = 0; LOin = 0; ZHighIn = 0; ZLowIn = 0;
    endtask

    // Apply the current strobes for one edge, then return to idle just after it.
    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
    endtask

    task automatic check_z(input string tag, input logic [31:0] lo_exp, input logic [31:0] hi_exp);
        Zlowout = 1; #1;
        check({tag, "_lo"}, BusMuxOut, lo_exp);
        Zlowout = 0; ZHighout = 1; #1;
        check({tag, "_hi"}, BusMuxOut, hi_exp);
        idle(); #1;
    endtask

    // Y <- yv via MDR, then bus <- bv via MDR, run op into both Z halves.
    task automatic run_alu(input logic [4:0] op, input logic [31:0] yv, input logic [31:0] bv,
                           input logic c);
        load_mdr(yv);
        MDRout = 1; Yin = 1; tick();
        load_mdr(bv);
        MDRout = 1; ROR = op; Cin = c; ZLowIn = 1; ZHighIn = 1; tick();
    endtask

    initial begin
        idle();
        Mdatain = '0;
        Clear = 1;
        tick();
        check("reset_bus", BusMuxOut, 32'h0);
        check("reset_mar", MARout, 32'h0);

        // Register loads through MDR: R4 = 0x12, R3 = 0x7F, R7 = 0x01
        load_mdr(32'h12);
        MDRout = 1; R4in = 1; #1;
        check("mdr_to_bus", BusMuxOut, 32'h12);
        tick();
        load_mdr(32'h7F);
        MDRout = 1; R3in = 1; tick();
        load_mdr(32'h01);
        MDRout = 1; R7in = 1; tick();
        R4out = 1; #1;
        check("r4_loaded", BusMuxOut, 32'h12);
        idle();

        // Rotate right R3 by R7 into Z, then move Z low into R4
        R7out = 1; Yin = 1; #1;
        check("r7_bus", BusMuxOut, 32'h1);
        tick();
        R3out = 1; ROR = 5'b00111; ZLowIn = 1; tick();
        Zlowout = 1; R4in = 1; #1;
        check("ror_bus", BusMuxOut, 32'h8000003F);
        tick();
        R4out = 1; #1;
        check("ror_r4", BusMuxOut, 32'h8000003F);
        idle();

        // Bus priority: MDR beats R3
        MDRout = 1; R3out = 1; #1;
        check("prio_mdr", BusMuxOut, 32'h1);
        MDRout = 0; #1;
        check("prio_r3", BusMuxOut, 32'h7F);
        idle();

        run_alu(5'b00000, 32'h12, 32'h7F, 1'b1);
        check_z("add_cin", 32'h00000092, 32'h0);
        run_alu(5'b01001, 32'h7F, 32'h12, 1'b0);
        check_z("mul_pos", 32'h000008EE, 32'h0);
        run_alu(5'b01001, 32'hFFFFFFFF, 32'h2, 1'b0);
        check_z("mul_neg", 32'hFFFFFFFE, 32'hFFFFFFFF);
        // High half must be cleared by non-MUL/DIV ops
        run_alu(5'b00101, 32'h4, 32'h80000000, 1'b0);
        check_z("shra", 32'hF8000000, 32'h0);
        run_alu(5'b01010, 32'h7, 32'h0, 1'b0);
        check_z("div_zero", 32'h0, 32'h7);
        run_alu(5'b01010, 32'hFFFFFFF9, 32'h2, 1'b0);
        check_z("div_neg", 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_alu(5'b00001, 32'h5, 32'h7, 1'b1);
        check_z("sub", 32'hFFFFFFFE, 32'h0);
        run_alu(5'b01000, 32'h4, 32'h80000001, 1'b0);
        check_z("rol", 32'h00000018, 32'h0);
        run_alu(5'b00111, 32'h20, 32'hA5A5_0F0F, 1'b0);
        check_z("ror_zero", 32'hA5A50F0F, 32'h0);
        run_alu(5'b01100, 32'h0, 32'h0000FFFF, 1'b0);
        check_z("not", 32'hFFFF0000, 32'h0);
        run_alu(5'b11111, 32'h3, 32'h5, 1'b0);
        check_z("undef_op", 32'h0, 32'h0);

        // Instruction fetch
        load_mdr(32'h7);
        MDRout = 1; PCin = 1; tick();
        PCout = 1; MARin = 1; IncPC = 1; #1;
        check("fetch_pc_bus", BusMuxOut, 32'h7);
        tick();
        check("fetch_mar", MARout, 32'h7);
        PCout = 1; #1;
        check("fetch_pc_inc", BusMuxOut, 32'h8);
        idle();
        load_mdr(32'h3A1B8000);
        MDRout = 1; IRin = 1; tick();
        check("fetch_ir", dut.ir, 32'h3A1B8000);

        // IncPC outranks PCin
        MDRout = 1; IncPC = 1; PCin = 1; tick();
        PCout = 1; #1;
        check("incpc_prio", BusMuxOut, 32'h9);
        idle();

        // Drive and load MDR in the same cycle: it recaptures its own value
        MDRout = 1; MDRin = 1; Read = 0; Mdatain = 32'hDEADBEEF; tick();
        MDRout = 1; #1;
        check("mdr_self", BusMuxOut, 32'h3A1B8000);
        idle();

        // Clear mid-sequence with strobes active
        Clear = 1; MDRout = 1; R4in = 1; PCin = 1; MARin = 1; ZLowIn = 1; Yin = 1;
        tick();
        PCout = 1; #1;
        check("clr_pc", BusMuxOut, 32'h0);
        PCout = 0; Zlowout = 1; #1;
        check("clr_zlo", BusMuxOut, 32'h0);
        Zlowout = 0; R4out = 1; #1;
        check("clr_r4", BusMuxOut, 32'h0);
        R4out = 0; #1;
        check("clr_mar", MARout, 32'h0);
        check("clr_ir", dut.ir, 32'h0);
        check("clr_idle_bus", BusMuxOut, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
